// File: rtl/diff_bus_tx.sv
// rtl/diff_bus_tx.sv - framed LSB-first differential line transmitter with programmable bit period
//
// Serializes bytes accepted over a valid/ready handshake onto a differential
// pair. Each frame is LEAD, START, DATA_W data bits, STOP and TAIL, and each
// part lasts one bit period of (div_q+1) clocks. A byte accepted in the last
// STOP cycle chains straight into START, so LEAD and TAIL are skipped. Between
// frames both legs are released so the receiver's regenerative load holds
// the last level.
//
// Ports:
//   clk       clock; all state changes on its rising edge
//   rst_n     asynchronous active-low reset
//   div       bit period minus one, sampled only on an accept from IDLE
//   in_data   byte to send
//   in_valid  in_data is valid
//   in_ready  byte taken on a cycle with in_valid && in_ready (combinational)
//   txp       positive leg drive level (registered)
//   txn       negative leg drive level (registered)
//   tx_oe     pad output enable for both legs (registered)
//   busy      high whenever the FSM is not IDLE (registered)

module diff_bus_tx #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  div,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              txp,
    output logic              txn,
    output logic              tx_oe,
    output logic              busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_START,
        S_DATA,
        S_STOP,
        S_TAIL
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DIV_W-1:0]  timer;
    logic [DIV_W-1:0]  timer_nx;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_q_nx;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nx;
    logic              txp_nx;
    logic              txn_nx;
    logic              oe_nx;
    logic              busy_nx;
    logic              period_end;
    logic              accept;

    // Last clock of the current bit period.
    assign period_end = (timer == div_q);

    // Ready only depends on registered state, never on in_valid, so there is
    // no combinational path from in_valid back to in_ready.
    assign in_ready = (state == S_IDLE) || ((state == S_STOP) && period_end);
    assign accept   = in_ready && in_valid;

    // Next-state logic for the FSM, bit timer, bit index and shift register.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        div_q_nx = div_q;
        idx_nx   = idx;
        shreg_nx = shreg;

        if (state == S_IDLE) begin
            timer_nx = '0;
            idx_nx   = '0;
            if (accept) begin
                state_nx = S_LEAD;
                // The period is latched only here; chained frames keep it.
                div_q_nx = div;
                shreg_nx = in_data;
            end
        end else if (!period_end) begin
            timer_nx = timer + 1'b1;
        end else begin
            timer_nx = '0;
            case (state)
                S_LEAD: begin
                    state_nx = S_START;
                end
                S_START: begin
                    state_nx = S_DATA;
                    idx_nx   = '0;
                end
                S_DATA: begin
                    if (idx == LAST_IDX) begin
                        state_nx = S_STOP;
                    end else begin
                        idx_nx   = idx + 1'b1;
                        // Bit 0 of the shift register is always the bit on the line.
                        shreg_nx = shreg >> 1;
                    end
                end
                S_STOP: begin
                    if (accept) begin
                        state_nx = S_START;
                        shreg_nx = in_data;
                    end else begin
                        state_nx = S_TAIL;
                    end
                end
                S_TAIL: begin
                    state_nx = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Line symbol for the next state. Registering it alongside the state keeps
    // the pad drive glitch-free and aligned with the state it belongs to.
    always_comb begin
        oe_nx   = 1'b1;
        busy_nx = 1'b1;
        txp_nx  = 1'b1;
        case (state_nx)
            S_IDLE: begin
                oe_nx   = 1'b0;
                busy_nx = 1'b0;
                txp_nx  = 1'b0;
            end
            S_START: txp_nx = 1'b0;
            S_DATA:  txp_nx = shreg_nx[0];
            default: txp_nx = 1'b1;
        endcase
        // txn is the complement only while driving, so both legs are never high.
        txn_nx = oe_nx & ~txp_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            timer <= '0;
            div_q <= '0;
            idx   <= '0;
            shreg <= '0;
            txp   <= 1'b0;
            txn   <= 1'b0;
            tx_oe <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            div_q <= div_q_nx;
            idx   <= idx_nx;
            shreg <= shreg_nx;
            txp   <= txp_nx;
            txn   <= txn_nx;
            tx_oe <= oe_nx;
            busy  <= busy_nx;
        end
    end

endmodule

// File: doc/diff_bus_tx.md
# diff_bus_tx

Differential line transmitter that drives the pbus/nbus pair sensed by the cross-coupled inverter receiver (active load plus XOR detect). It accepts bytes over a valid/ready handshake and serializes each one as a framed, LSB-first bit stream with a programmable bit period. Between frames it releases the pair so the receiver's regenerative load holds state. It sits in the digital shell next to the pad drivers; `txp`/`txn`/`tx_oe` go to the tri-state pad cells.

## Interface
- `DATA_W`, default 8: payload bits per frame.
- `DIV_W`, default 8: width of the bit-period divider.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `div`  in  DIV_W: bit period is `div+1` clocks. Sampled at frame start.
- `in_data`  in  DATA_W: byte to send.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the block accepts `in_data` on a cycle where `in_valid && in_ready`.
- `txp`  out  1: positive leg drive level.
- `txn`  out  1: negative leg drive level.
- `tx_oe`  out  1: pad output enable for both legs.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- Line symbols:
  - Diff-1 is `txp=1, txn=0`.
  - Diff-0 is `txp=0, txn=1`.
  - Released is `tx_oe=0, txp=0, txn=0`.
  - `txp` and `txn` are never both 1.
- FSM states and the symbol driven in each:
  - IDLE: released.
  - LEAD: diff-1. Lets the receiver latch settle.
  - START: diff-0.
  - DATA: `DATA_W` bits, LSB first. Bit=1 is diff-1.
  - STOP: diff-1.
  - TAIL: diff-1.
  - Every state except IDLE drives `tx_oe=1`.
- Each non-IDLE state lasts exactly one bit period, except DATA, which lasts `DATA_W` bit periods.
- A bit timer counts 0..`div_q`. A bit-index counter of width clog2(DATA_W) counts data bits.
- Transitions:
  - IDLE→LEAD on accept.
  - LEAD→START, START→DATA, DATA→STOP after the last data bit.
  - STOP→START if a byte is accepted in the final STOP cycle; otherwise STOP→TAIL.
  - TAIL→IDLE.
- `in_ready` = (state==IDLE) OR (state==STOP AND bit timer==`div_q`). It is combinational from registered state and does not depend on `in_valid`.
- On accept, `in_data` is copied into a shift register. LSB is sent first.
- `div` is registered into `div_q` only on an accept from IDLE. Back-to-back frames reuse `div_q`. Changes to `div` mid-burst are ignored.
- `in_data` and `in_valid` are don't-care while `in_ready=0`. No data is ever dropped or duplicated.
- Reset:
  - Asynchronously forces IDLE, `tx_oe=0`, `txp=0`, `txn=0`, `busy=0`.
  - Clears the counters and `div_q`.
  - `in_ready=1` after reset.
  - Reset during a frame abandons that frame immediately; the partial byte is not resent.

## Timing
- All outputs except `in_ready` are registered.
- Accept from IDLE on edge k:
  - LEAD is driven from cycle k+1.
  - START begins at k+1+P, where P=`div`+1.
  - Data bit i is driven during [k+1+(2+i)P, k+1+(3+i)P).
  - STOP begins at k+1+(2+DATA_W)P.
  - TAIL follows.
  - `tx_oe` falls at k+1+(4+DATA_W)P, which is 12P after k+1 for DATA_W=8.
- Back-to-back: an accept in the final STOP cycle makes START follow STOP with no LEAD and no TAIL. Frame spacing is then (DATA_W+2)P clocks.
- With `div`=0, every state lasts one clock and the bench must still see every symbol.
- Max throughput is one byte per (DATA_W+2)P clocks. `in_ready` is high for exactly one clock per frame during bursts.

## Test plan
- Reset, `div`=0, send 0xA5:
  - `tx_oe` high 12 cycles.
  - `txp` sequence 1,0,1,0,1,0,0,1,0,1,1,1 (LEAD, START, data LSB-first, STOP, TAIL).
  - `busy` drops with `tx_oe`.
  - `txn` = ~`txp` throughout.
- `div`=3, send 0x01: every symbol lasts 4 cycles; `tx_oe` high exactly 48 cycles after the accept edge.
- Burst 0x00,0xFF,0x3C with `in_valid` held high, `div`=0:
  - One LEAD, three START/DATA/STOP groups 10 cycles apart, one TAIL.
  - `in_ready` pulses once per STOP end.
- Change `div` from 0 to 7 mid-frame: the frame and any chained frames keep 1-cycle bits; the next frame started from IDLE uses 8-cycle bits.
- Assert `rst_n`=0 during DATA bit 4: outputs go released asynchronously (before the next edge), `busy`=0, `in_ready`=1. A new byte after deassertion starts with LEAD.
- Drop `in_valid` during the final STOP cycle: TAIL is sent, then release. Raising `in_valid` one cycle later is accepted only once IDLE is reached.
